// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: the per-register action encoding
// understood by both the register chain and the hazard unit.
package cpu_pkg;

    typedef logic [1:0] stage_act_t;

    localparam stage_act_t ACT_ADVANCE = 2'd0;
    localparam stage_act_t ACT_HOLD    = 2'd1;
    localparam stage_act_t ACT_BUBBLE  = 2'd2;
    localparam stage_act_t ACT_FLUSH   = 2'd3;

endpackage

// File: rtl/pl_stage.sv
// One pipeline register: valid bit plus payload, driven by a decoded action.
module pl_stage import cpu_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  stage_act_t            action,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (action)
                ACT_ADVANCE: begin
                    valid <= load_valid;
                    data  <= load_data;
                end
                // Bubbles and flushes both clear the payload so dead entries read as zero.
                ACT_BUBBLE, ACT_FLUSH: begin
                    valid <= 1'b0;
                    data  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pl_chain.sv
// STAGES-deep pipeline register chain with hazard-driven hold/flush,
// internal stall propagation, bubble insertion and retire/bubble counters.
module pl_chain import cpu_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 5,
    parameter int CNT_WIDTH  = 32,
    localparam int OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     hold,
    input  logic [STAGES-1:0]     flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [STAGES-1:0]     stage_valid,
    output logic [OCC_W-1:0]      occupancy,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    logic [STAGES-1:0]                 eff_hold;
    logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;
    stage_act_t [STAGES-1:0]           action;
    logic                              retire;

    // Any downstream hold stalls everything upstream of it.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        eff_hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc         = acc | hold[k];
            eff_hold[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                  up_hold;
        logic                  ld_valid;
        logic [DATA_WIDTH-1:0] ld_data;

        if (k == 0) begin : g_head
            assign up_hold  = 1'b0;
            assign ld_valid = in_valid;
            assign ld_data  = in_data;
        end else begin : g_body
            assign up_hold  = eff_hold[k-1];
            assign ld_valid = stage_valid[k-1];
            assign ld_data  = data_q[k-1];
        end

        assign action[k] = flush[k]    ? ACT_FLUSH  :
                           eff_hold[k] ? ACT_HOLD   :
                           up_hold     ? ACT_BUBBLE : ACT_ADVANCE;

        pl_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .action     (action[k]),
            .load_valid (ld_valid),
            .load_data  (ld_data),
            .valid      (stage_valid[k]),
            .data       (data_q[k])
        );
    end

    assign in_ready  = ~eff_hold[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++)
            occupancy = occupancy + OCC_W'(stage_valid[k]);
    end

    // A flushed or held last register does not hand its entry onward.
    assign retire = out_valid & ~flush[STAGES-1] & ~eff_hold[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (retire)
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            if (!out_valid)
                bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pl_chain.sv
// Scoreboard bench for pl_chain: a per-register reference of the pipeline
// feeds an expected-retire queue drained by an independent output monitor.
module tb_pl_chain;

    localparam int DW  = 32;
    localparam int S   = 5;
    localparam int CW  = 4;
    localparam int OW  = $clog2(S + 1);
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [S-1:0]  hold = '0;
    logic [S-1:0]  flush = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [S-1:0]  stage_valid;
    logic [OW-1:0] occupancy;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] retire_cnt;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pl_chain #(.DATA_WIDTH(DW), .STAGES(S), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
        .occupancy(occupancy), .cnt_clr(cnt_clr),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    logic [DW-1:0] exp_q[$];
    bit            cur_v[S], nxt_v[S];
    logic [DW-1:0] cur_d[S], nxt_d[S];
    int            cur_rc, cur_bc, nxt_rc, nxt_bc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void model_zero();
        for (int k = 0; k < S; k++) begin
            cur_v[k] = 0; cur_d[k] = '0; nxt_v[k] = 0; nxt_d[k] = '0;
        end
        cur_rc = 0; cur_bc = 0; nxt_rc = 0; nxt_bc = 0;
        exp_q.delete();
    endfunction

    function automatic void commit();
        for (int k = 0; k < S; k++) begin
            cur_v[k] = nxt_v[k]; cur_d[k] = nxt_d[k];
        end
        cur_rc = nxt_rc; cur_bc = nxt_bc;
    endfunction

    // Next state from the current inputs; a retiring entry is queued for the monitor.
    function automatic void predict();
        bit stalled[S];
        bit any = 0;
        for (int k = S - 1; k >= 0; k--) begin
            any = any | hold[k];
            stalled[k] = any;
        end
        for (int k = 0; k < S; k++) begin
            if (flush[k]) begin
                nxt_v[k] = 0; nxt_d[k] = '0;
            end else if (stalled[k]) begin
                nxt_v[k] = cur_v[k]; nxt_d[k] = cur_d[k];
            end else if (k > 0 && stalled[k-1]) begin
                nxt_v[k] = 0; nxt_d[k] = '0;
            end else if (k == 0) begin
                nxt_v[k] = in_valid; nxt_d[k] = in_data;
            end else begin
                nxt_v[k] = cur_v[k-1]; nxt_d[k] = cur_d[k-1];
            end
        end
        nxt_rc = cur_rc;
        nxt_bc = cur_bc;
        if (cur_v[S-1] && !flush[S-1] && !stalled[S-1]) begin
            exp_q.push_back(cur_d[S-1]);
            nxt_rc = (cur_rc + 1) % MOD;
        end
        if (!cur_v[S-1]) nxt_bc = (cur_bc + 1) % MOD;
        if (cnt_clr) begin
            nxt_rc = 0; nxt_bc = 0;
        end
    endfunction

    task automatic tick(input bit iv, input logic [DW-1:0] d, input logic [S-1:0] h,
                        input logic [S-1:0] f, input bit clr);
        @(posedge clk);
        #1;
        commit();
        in_valid = iv; in_data = d; hold = h; flush = f; cnt_clr = clr;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, $urandom, '0, '0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_stage_valid"}, stage_valid, 0);
        chk({tag, "_occupancy"}, occupancy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_retire_cnt"}, retire_cnt, 0);
        chk({tag, "_bubble_cnt"}, bubble_cnt, 0);
    endtask

    // Reset lands between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #1;
        commit();
        in_valid = 0; hold = '0; flush = '0; cnt_clr = 0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        model_zero();
        @(posedge clk);
        #1;
        commit();
        rst = 1'b0;
        predict();
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            logic [S-1:0] mv;
            int           cnt;
            cnt = 0;
            for (int k = 0; k < S; k++) begin
                mv[k] = cur_v[k];
                cnt += int'(cur_v[k]);
            end
            chk("stage_valid", stage_valid, mv);
            chk("occupancy", occupancy, cnt);
            chk("in_ready", in_ready, !(|hold));
            chk("retire_cnt", retire_cnt, cur_rc);
            chk("bubble_cnt", bubble_cnt, cur_bc);
            if (out_valid && !flush[S-1] && !hold[S-1]) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL retire_unexpected actual=%0h required=none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] val;
        model_zero();
        #2 check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        predict();

        // Streaming 1..8 after a counter clear.
        tick(0, '0, '0, '0, 1);
        for (int i = 1; i <= 8; i++) tick(1, i, '0, '0, 0);
        idle(6);
        chk("stream_retire", retire_cnt, 8);
        chk("stream_bubble", bubble_cnt, 5);

        // Hold on register 2 for two cycles mid-stream; data re-presented while stalled.
        val = 32'h100;
        for (int i = 0; i < 10; i++) begin
            logic [S-1:0] h;
            h = (i == 3 || i == 4) ? 5'b00100 : 5'b00000;
            tick(1, val, h, '0, 0);
            if (h != 0) begin
                #1 chk("hold_in_ready", in_ready, 0);
            end else begin
                val++;
            end
        end

        // Flush registers 0,1 while register 0 is held.
        tick(1, 32'h200, 5'b00001, 5'b00011, 0);
        tick(1, 32'h201, '0, '0, 0);
        chk("flush01_valid", stage_valid[1:0], 2'b00);
        idle(6);

        // Flush the last register while it holds 0xDEAD.
        tick(1, 32'hDEAD, '0, '0, 0);
        idle(4);
        tick(0, '0, '0, 5'b10000, 0);
        chk("dead_present", {out_valid, out_data}, {1'b1, 32'hDEAD});
        tick(0, '0, '0, '0, 0);
        chk("dead_flushed", out_valid, 0);
        idle(2);

        // Sixteen retires wrap a 4-bit counter back to zero.
        tick(0, '0, '0, '0, 1);
        for (int i = 0; i < 16; i++) tick(1, 32'h300 + i, '0, '0, 0);
        idle(6);
        chk("wrap_retire", retire_cnt, 0);
        chk("wrap_bubble", bubble_cnt, 5);

        // Clear coinciding with a retire.
        for (int i = 0; i < 6; i++) tick(1, 32'h400 + i, '0, '0, 0);
        tick(1, 32'h406, '0, '0, 1);
        tick(0, '0, '0, '0, 0);
        chk("clr_on_retire", retire_cnt, 0);

        // Asynchronous reset with a full pipeline, then resume.
        for (int i = 0; i < 5; i++) tick(1, 32'h500 + i, '0, '0, 0);
        async_reset();
        for (int i = 0; i < 6; i++) tick(1, 32'h600 + i, '0, '0, 0);
        idle(6);

        // Randomized traffic with sparse holds, flushes and clears.
        for (int i = 0; i < 400; i++) begin
            logic [S-1:0] h, f;
            h = ($urandom % 5 == 0) ? S'($urandom) : '0;
            f = ($urandom % 7 == 0) ? S'($urandom) : '0;
            tick(($urandom % 4) != 0, $urandom, h, f, ($urandom % 40) == 0);
            if (i == 200) async_reset();
        end
        idle(8);
        tick(0, '0, '0, '0, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pl_chain.md
# pl_chain

Parametrised successor to the fixed per-stage pipeline registers (fetch/decode, decode/execute, execute/memory, memory/writeback). It is a STAGES-deep chain of pipeline registers carrying a DATA_WIDTH-bit payload with per-entry valid bits. Per-stage hold and flush vectors come from the hazard unit. The chain derives stall propagation and bubble insertion internally and keeps retire/bubble performance counters.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width per stage
- STAGES, 5, number of pipeline registers (≥2)
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  entry presented to stage 0
- in_data  in  DATA_WIDTH  payload presented to stage 0
- in_ready  out  1  stage 0 will load this cycle (= !eff_hold[0])
- hold  in  STAGES  per-register hold request from hazard unit
- flush  in  STAGES  per-register flush request
- out_valid  out  1  valid bit of register STAGES-1
- out_data  out  DATA_WIDTH  payload of register STAGES-1
- stage_valid  out  STAGES  valid bit of every register
- occupancy  out  $clog2(STAGES+1)  popcount of stage_valid
- cnt_clr  in  1  synchronous clear of both counters
- retire_cnt  out  CNT_WIDTH  entries leaving the last register
- bubble_cnt  out  CNT_WIDTH  cycles with out_valid=0

## Operation
- Effective hold: eff_hold[k] = OR of hold[j] for j ≥ k. A downstream hold always stalls every upstream register.
- Per register k, per edge, the action is the first match in this priority order:
  - FLUSH: flush[k]=1 → valid=0, data=0.
  - HOLD: eff_hold[k]=1 → keep contents.
  - BUBBLE: k>0 and eff_hold[k-1]=1 → valid=0, data=0.
  - ADVANCE: load from register k-1. Register 0 loads in_valid/in_data.
- Flush overrides hold in the same register. A flushed upstream register loads 0 even when held.
- Retire event: out_valid=1, flush[STAGES-1]=0 and eff_hold[STAGES-1]=0 in the same cycle.
- retire_cnt increments on each retire event. bubble_cnt increments every cycle out_valid=0. Both wrap modulo 2^CNT_WIDTH.
- cnt_clr=1 zeroes both counters at the next edge and takes priority over increment. Pipeline contents are unaffected.
- in_valid=0 with in_ready=1 loads a bubble into register 0. in_data is not required to be stable when in_valid=0.

## Timing
- Reset (async assert, sync release implied by upstream reset synchroniser): all valids=0, all data=0, counters=0.
  - Resulting outputs: out_valid=0, out_data=0, stage_valid=0, occupancy=0, in_ready=1.
  - Reset mid-operation discards all entries immediately; counters restart from 0.
- Latency: an entry accepted at edge t reaches register k at edge t+k. With no holds, out_valid rises after STAGES edges.
- in_ready, out_*, stage_valid and occupancy are decoded from registers and the current hold input only. There is no combinational path from flush to in_ready.
- Throughput is one entry per cycle when hold=0.
- Simultaneous flush and hold on the same register: flush wins. Simultaneous flush and retire on the last register: no retire count.
- Counter wrap: all-ones +1 → 0, no saturation.

## Structure
- The shared package cpu_pkg holds the stage-action encoding (ADVANCE, HOLD, BUBBLE, FLUSH) as localparams, used by both the chain and the hazard unit.
- Sub-module pl_stage: one register with valid bit, data and a 2-bit action input. It is instantiated STAGES times in a generate loop.
- The top level holds the eff_hold prefix-OR, the action decode, the popcount and the two counters.

## Test plan
All scenarios use STAGES=5 and DATA_WIDTH=32.
- Streaming: in_valid=1 with data 1..8 on consecutive cycles, hold=0 → out_data shows 1..8 on cycles 5..12; retire_cnt=8; bubble_cnt=5 after 13 cycles.
- Hold on register 2 for 2 cycles mid-stream → registers 0–2 frozen and in_ready=0 for 2 cycles; 2 bubbles appear in register 3; stream order preserved with no loss or duplication.
- flush=5'b00011 together with hold=5'b00001 → registers 0,1 invalid next cycle; occupancy drops by the number of valid entries flushed.
- Flush of register 4 while it holds 0xDEAD and it is not held → no retire counted, out_valid=0 next cycle, bubble_cnt +1.
- Counter wrap and clear (CNT_WIDTH=4): after 16 retires retire_cnt=0. cnt_clr asserted in the same cycle as a retire → counter reads 0.
- rst asserted asynchronously between edges with 5 valid entries → all outputs at reset values before the next edge; normal streaming resumes after deassertion.
